// File: rtl/player_pkg.sv
// Shared constants and button decoding for the player mover.
// Optional diagonal movement is enabled by defining PLAYER_DIAGONAL_EN.
package player_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FIRST  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam logic [1:0] ST_DEAD   = 2'd3;

  localparam int unsigned DIR_U = 3;
  localparam int unsigned DIR_D = 2;
  localparam int unsigned DIR_R = 1;
  localparam int unsigned DIR_L = 0;
  localparam int unsigned DIR_W = 4;

  localparam int unsigned SCREEN_W_DFLT = 640;
  localparam int unsigned SCREEN_H_DFLT = 480;

  // A button pattern is actionable when exactly one direction (or one per axis) is pressed.
  function automatic logic btnValid(input logic [DIR_W-1:0] b);
    logic oneHot;
    oneHot = (b != 4'b0000) && ((b & (b - 4'd1)) == 4'b0000);
`ifdef PLAYER_DIAGONAL_EN
    return oneHot || ((b[DIR_U] ^ b[DIR_D]) && (b[DIR_R] ^ b[DIR_L]));
`else
    return oneHot;
`endif
  endfunction

endpackage

// File: rtl/player_mover_if.sv
// Control and position bus between the game logic and one player mover.
interface player_mover_if
  import player_pkg::*;
#(
  parameter int unsigned POS_W = 12
);
  logic             playerDisable;
  logic [DIR_W-1:0] dirEnable;
  logic [DIR_W-1:0] btns;
  logic             respawn;
  logic [POS_W-1:0] hStartPos;
  logic [POS_W-1:0] vStartPos;
  logic [POS_W-1:0] objWidth;
  logic [POS_W-1:0] objHeight;
  logic [POS_W-1:0] hPos;
  logic [POS_W-1:0] vPos;
  logic             moved;
  logic             player_dead;
  logic             is_dead;
  logic [1:0]       state;

  modport master (
    output playerDisable, dirEnable, btns, respawn,
           hStartPos, vStartPos, objWidth, objHeight,
    input  hPos, vPos, moved, player_dead, is_dead, state
  );

  modport slave (
    input  playerDisable, dirEnable, btns, respawn,
           hStartPos, vStartPos, objWidth, objHeight,
    output hPos, vPos, moved, player_dead, is_dead, state
  );
endinterface

// File: rtl/player_mover_axis_stepper.sv
// Next position along one axis for a single step, with wrap or clamp at the screen edge.
module axis_stepper #(
  parameter int unsigned POS_W     = 12,
  parameter int unsigned STEP      = 12,
  parameter int unsigned WRAP_MODE = 1
) (
  input  logic [POS_W-1:0] cur,
  input  logic [POS_W-1:0] size,
  input  logic [POS_W-1:0] limit,
  input  logic             dec,
  input  logic             inc,
  input  logic             en,
  output logic [POS_W-1:0] nextPos_c
);
  localparam int unsigned EXT_W = POS_W + 1;

  logic [EXT_W-1:0] curX;
  logic [EXT_W-1:0] maxX;
  logic [EXT_W-1:0] stepX;
  logic [EXT_W-1:0] sumX;

  assign curX  = {1'b0, cur};
  assign maxX  = {1'b0, limit} - {1'b0, size};
  assign stepX = EXT_W'(STEP);
  assign sumX  = curX + stepX;

  always_comb begin
    nextPos_c = cur;
    if (en && dec) begin
      if (curX >= stepX) nextPos_c = POS_W'(curX - stepX);
      else               nextPos_c = (WRAP_MODE != 0) ? POS_W'(maxX) : '0;
    end else if (en && inc) begin
      if (sumX <= maxX)  nextPos_c = POS_W'(sumX);
      else               nextPos_c = (WRAP_MODE != 0) ? '0 : POS_W'(maxX);
    end
  end
endmodule

// File: rtl/player_mover.sv
// Steps one player rectangle on button input with hold-to-repeat and a death/respawn FSM.
// Diagonal presses are accepted when PLAYER_DIAGONAL_EN is defined (see player_pkg).
module player_mover
  import player_pkg::*;
#(
  parameter int unsigned POS_W       = 12,
  parameter int unsigned SCREEN_W    = SCREEN_W_DFLT,
  parameter int unsigned SCREEN_H    = SCREEN_H_DFLT,
  parameter int unsigned STEP        = 12,
  parameter int unsigned WRAP_MODE   = 1,
  parameter int unsigned REPEAT_DLY  = 8,
  parameter int unsigned REPEAT_RATE = 4,
  parameter int unsigned CNT_W       = 8
) (
  input logic           btnClk,
  input logic           rst,
  player_mover_if.slave bus
);
  logic [1:0]       stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic [DIR_W-1:0] heldQ, heldD;
  logic [POS_W-1:0] hPosQ, hPosD, vPosQ, vPosD;
  logic             movedQ, movedD;
  logic             deadPulseQ, deadPulseD;
  logic             isDeadQ, isDeadD;
  logic             doStep;
  logic [POS_W-1:0] hStep_c, vStep_c;
  logic             hEn_c, vEn_c;

  // Per-axis permission follows whichever direction on that axis is pressed.
  assign hEn_c = bus.btns[DIR_L] ? bus.dirEnable[DIR_L] : bus.dirEnable[DIR_R];
  assign vEn_c = bus.btns[DIR_U] ? bus.dirEnable[DIR_U] : bus.dirEnable[DIR_D];

  axis_stepper #(.POS_W(POS_W), .STEP(STEP), .WRAP_MODE(WRAP_MODE)) xStep (
    .cur(hPosQ), .size(bus.objWidth), .limit(POS_W'(SCREEN_W)),
    .dec(bus.btns[DIR_L]), .inc(bus.btns[DIR_R]), .en(hEn_c), .nextPos_c(hStep_c)
  );

  axis_stepper #(.POS_W(POS_W), .STEP(STEP), .WRAP_MODE(WRAP_MODE)) yStep (
    .cur(vPosQ), .size(bus.objHeight), .limit(POS_W'(SCREEN_H)),
    .dec(bus.btns[DIR_U]), .inc(bus.btns[DIR_D]), .en(vEn_c), .nextPos_c(vStep_c)
  );

  always_ff @(posedge btnClk) begin
    if (!rst) begin
      stateQ     <= ST_IDLE;
      cntQ       <= '0;
      heldQ      <= '0;
      hPosQ      <= bus.hStartPos;
      vPosQ      <= bus.vStartPos;
      movedQ     <= 1'b0;
      deadPulseQ <= 1'b0;
      isDeadQ    <= 1'b0;
    end else begin
      stateQ     <= stateD;
      cntQ       <= cntD;
      heldQ      <= heldD;
      hPosQ      <= hPosD;
      vPosQ      <= vPosD;
      movedQ     <= movedD;
      deadPulseQ <= deadPulseD;
      isDeadQ    <= isDeadD;
    end
  end

  // Death has priority over stepping; a disabled player is frozen entirely.
  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    heldD      = heldQ;
    hPosD      = hPosQ;
    vPosD      = vPosQ;
    deadPulseD = 1'b0;
    isDeadD    = isDeadQ;
    doStep     = 1'b0;

    if (!bus.playerDisable) begin
      if (stateQ == ST_DEAD) begin
        if (bus.respawn) begin
          stateD  = ST_IDLE;
          cntD    = '0;
          hPosD   = bus.hStartPos;
          vPosD   = bus.vStartPos;
          isDeadD = 1'b0;
        end
      end else if (bus.dirEnable == 4'b0000) begin
        stateD     = ST_DEAD;
        cntD       = '0;
        deadPulseD = 1'b1;
        isDeadD    = 1'b1;
      end else begin
        case (stateQ)
          ST_IDLE: begin
            if (btnValid(bus.btns)) begin
              doStep = 1'b1;
              cntD   = '0;
              heldD  = bus.btns;
              stateD = ST_FIRST;
            end
          end
          ST_FIRST: begin
            if (bus.btns != heldQ) begin
              stateD = ST_IDLE;
            end else if (cntQ == CNT_W'(REPEAT_DLY - 1)) begin
              doStep = 1'b1;
              cntD   = '0;
              stateD = ST_REPEAT;
            end else begin
              cntD = cntQ + CNT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (bus.btns != heldQ) begin
              stateD = ST_IDLE;
            end else if (cntQ == CNT_W'(REPEAT_RATE - 1)) begin
              doStep = 1'b1;
              cntD   = '0;
            end else begin
              cntD = cntQ + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end

    if (doStep) begin
      hPosD = hStep_c;
      vPosD = vStep_c;
    end
    movedD = (hPosD != hPosQ) || (vPosD != vPosQ);
  end

  assign bus.hPos        = hPosQ;
  assign bus.vPos        = vPosQ;
  assign bus.moved       = movedQ;
  assign bus.player_dead = deadPulseQ;
  assign bus.is_dead     = isDeadQ;
  assign bus.state       = stateQ;
endmodule

// File: tb/tb_player_mover.sv
// Bench for player_mover: a wrapping and a clamping instance share stimulus and are
// checked every cycle against a hold-duration model, plus hand-computed expectations.
module tb_player_mover;
  localparam int STEP = 12;
  localparam int DLY  = 8;
  localparam int RATE = 4;
  localparam int SW   = 640;
  localparam int SH   = 480;

  logic        btnClk = 1'b0;
  logic        rst;
  logic        playerDisable;
  logic [3:0]  dirEnable;
  logic [3:0]  btns;
  logic        respawn;
  logic [11:0] hStart, vStart, objWidth, objHeight;

  int nChecks = 0;
  int nFail   = 0;

  always #5 btnClk = ~btnClk;

  player_mover_if #(.POS_W(12)) busW ();
  player_mover_if #(.POS_W(12)) busC ();

  assign busW.playerDisable = playerDisable;
  assign busW.dirEnable     = dirEnable;
  assign busW.btns          = btns;
  assign busW.respawn       = respawn;
  assign busW.hStartPos     = hStart;
  assign busW.vStartPos     = vStart;
  assign busW.objWidth      = objWidth;
  assign busW.objHeight     = objHeight;
  assign busC.playerDisable = playerDisable;
  assign busC.dirEnable     = dirEnable;
  assign busC.btns          = btns;
  assign busC.respawn       = respawn;
  assign busC.hStartPos     = hStart;
  assign busC.vStartPos     = vStart;
  assign busC.objWidth      = objWidth;
  assign busC.objHeight     = objHeight;

  player_mover #(.WRAP_MODE(1)) dutW (.btnClk(btnClk), .rst(rst), .bus(busW));
  player_mover #(.WRAP_MODE(0)) dutC (.btnClk(btnClk), .rst(rst), .bus(busC));

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         started = 1'b0;
  int         holdLen;
  logic [3:0] held;
  bit         mDead, mPd, doStep;
  int         mH[2], mV[2], pH[2], pV[2];
  bit         mMoved[2];

  function automatic bit mValid(input logic [3:0] b);
`ifdef PLAYER_DIAGONAL_EN
    if ($countones(b) == 2 && b[3] != b[2] && b[1] != b[0]) return 1'b1;
`endif
    return $countones(b) == 1;
  endfunction

  function automatic int stepAxis(input int cur, input int size, input int lim,
                                  input bit decP, input bit incP,
                                  input bit decE, input bit incE, input bit wrap);
    int mx;
    mx = lim - size;
    if (decP && decE) return (cur >= STEP) ? cur - STEP : (wrap ? mx : 0);
    if (incP && incE) return (cur + STEP <= mx) ? cur + STEP : (wrap ? 0 : mx);
    return cur;
  endfunction

  function automatic int expState();
    if (mDead) return 3;
    if (holdLen == 0) return 0;
    if (holdLen < DLY + 1) return 1;
    return 2;
  endfunction

  always @(posedge btnClk) begin
    mPd = 1'b0;
    if (!rst) begin
      started = 1'b1;
      holdLen = 0;
      mDead   = 1'b0;
      for (int i = 0; i < 2; i++) begin
        mH[i] = int'(hStart); mV[i] = int'(vStart); mMoved[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin pH[i] = mH[i]; pV[i] = mV[i]; end
      if (!playerDisable) begin
        if (mDead) begin
          if (respawn) begin
            mDead = 1'b0; holdLen = 0;
            for (int i = 0; i < 2; i++) begin mH[i] = int'(hStart); mV[i] = int'(vStart); end
          end
        end else if (dirEnable == 4'b0000) begin
          mDead = 1'b1; mPd = 1'b1; holdLen = 0;
        end else begin
          doStep = 1'b0;
          if (holdLen == 0) begin
            if (mValid(btns)) begin holdLen = 1; held = btns; doStep = 1'b1; end
          end else if (btns != held) begin
            holdLen = 0;
          end else begin
            holdLen++;
            if (holdLen >= DLY + 1 && (holdLen - DLY - 1) % RATE == 0) doStep = 1'b1;
          end
          if (doStep)
            for (int i = 0; i < 2; i++) begin
              mH[i] = stepAxis(mH[i], int'(objWidth), SW, btns[0], btns[1],
                               dirEnable[0], dirEnable[1], i == 0);
              mV[i] = stepAxis(mV[i], int'(objHeight), SH, btns[3], btns[2],
                               dirEnable[3], dirEnable[2], i == 0);
            end
        end
      end
      for (int i = 0; i < 2; i++) mMoved[i] = (mH[i] != pH[i]) || (mV[i] != pV[i]);
    end
  end

  task automatic cmpOne(input string tag, input int i, input int h, input int v,
                        input int mv, input int pd, input int dd, input int st);
    check({tag, ".hPos"}, h, mH[i]);
    check({tag, ".vPos"}, v, mV[i]);
    check({tag, ".moved"}, mv, int'(mMoved[i]));
    check({tag, ".player_dead"}, pd, int'(mPd));
    check({tag, ".is_dead"}, dd, int'(mDead));
    check({tag, ".state"}, st, expState());
  endtask

  always @(posedge btnClk) begin
    #1;
    if (started) begin
      cmpOne("wrap", 0, int'(busW.hPos), int'(busW.vPos), int'(busW.moved),
             int'(busW.player_dead), int'(busW.is_dead), int'(busW.state));
      cmpOne("clamp", 1, int'(busC.hPos), int'(busC.vPos), int'(busC.moved),
             int'(busC.player_dead), int'(busC.is_dead), int'(busC.state));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic edgeChk();
    @(posedge btnClk);
    #1;
  endtask

  initial begin
    rst = 1'b0; btns = 4'b0000; dirEnable = 4'b1111; playerDisable = 1'b0; respawn = 1'b0;
    hStart = 12'd100; vStart = 12'd200; objWidth = 12'd32; objHeight = 12'd32;
    edgeChk(); edgeChk();
    check("reset_h", int'(busW.hPos), 100);
    check("reset_v", int'(busW.vPos), 200);
    check("reset_state", int'(busW.state), 0);
    check("reset_dead", int'(busW.is_dead), 0);

    // single left press
    @(negedge btnClk) rst = 1'b1;
    @(negedge btnClk) btns = 4'b0001;
    edgeChk();
    check("left_h", int'(busW.hPos), 88);
    check("left_v", int'(busW.vPos), 200);
    check("left_moved", int'(busW.moved), 1);
    @(negedge btnClk) btns = 4'b0000;
    edgeChk();
    check("left_moved_once", int'(busW.moved), 0);
    check("left_release_state", int'(busW.state), 0);

    // left edge: wrap vs clamp
    @(negedge btnClk) begin rst = 1'b0; hStart = 12'd0; end
    edgeChk();
    @(negedge btnClk) begin rst = 1'b1; btns = 4'b0001; end
    edgeChk();
    check("wrap_left_h", int'(busW.hPos), 608);
    check("clamp_left_h", int'(busC.hPos), 0);
    check("clamp_left_moved", int'(busC.moved), 0);
    @(negedge btnClk) btns = 4'b0000;
    edgeChk();

    // right edge from 600 (hMax 608)
    @(negedge btnClk) begin rst = 1'b0; hStart = 12'd600; end
    edgeChk();
    @(negedge btnClk) begin rst = 1'b1; btns = 4'b0010; end
    edgeChk();
    check("wrap_right_h", int'(busW.hPos), 0);
    check("clamp_right_h", int'(busC.hPos), 608);
    @(negedge btnClk) btns = 4'b0000;
    edgeChk();
    @(negedge btnClk) btns = 4'b0010;
    edgeChk();
    check("clamp_right_stuck_moved", int'(busC.moved), 0);
    @(negedge btnClk) btns = 4'b0000;
    edgeChk();

    // bottom edge from 440 (vMax 448)
    @(negedge btnClk) begin rst = 1'b0; hStart = 12'd100; vStart = 12'd440; end
    edgeChk();
    @(negedge btnClk) begin rst = 1'b1; btns = 4'b0100; end
    edgeChk();
    check("wrap_down_v", int'(busW.vPos), 0);
    check("clamp_down_v", int'(busC.vPos), 448);
    @(negedge btnClk) btns = 4'b0000;
    edgeChk();

    // hold down 20 cycles from v=0: steps at 1, 9, 13, 17
    @(negedge btnClk) begin rst = 1'b0; vStart = 12'd0; end
    edgeChk();
    @(negedge btnClk) begin rst = 1'b1; btns = 4'b0100; end
    for (int k = 1; k <= 20; k++) begin
      edgeChk();
      if (k == 1) check("hold_k1_v", int'(busW.vPos), 12);
      if (k == 8) check("hold_k8_v", int'(busW.vPos), 12);
      if (k == 9) check("hold_k9_v", int'(busW.vPos), 24);
      if (k == 9) check("hold_k9_state", int'(busW.state), 2);
    end
    check("hold_final_v", int'(busW.vPos), 48);
    check("hold_final_v_clamp", int'(busC.vPos), 48);
    @(negedge btnClk) btns = 4'b0000;
    edgeChk();

    // button change: no step on change, new button next cycle
    @(negedge btnClk) btns = 4'b0001;
    repeat (3) edgeChk();
    @(negedge btnClk) btns = 4'b0010;
    edgeChk();
    check("change_state", int'(busW.state), 0);
    check("change_h", int'(busW.hPos), 88);
    edgeChk();
    check("change_next_h", int'(busW.hPos), 100);
    @(negedge btnClk) btns = 4'b0000;
    edgeChk();

    // suppressed direction still advances timing
    @(negedge btnClk) begin dirEnable = 4'b1110; btns = 4'b0001; end
    edgeChk();
    check("suppress_h", int'(busW.hPos), 100);
    check("suppress_moved", int'(busW.moved), 0);
    check("suppress_state", int'(busW.state), 1);
    @(negedge btnClk) begin dirEnable = 4'b1111; btns = 4'b0000; end
    edgeChk();

    // disable freezes everything, even with dirEnable all zero
    @(negedge btnClk) btns = 4'b1000;
    edgeChk();
    @(negedge btnClk) playerDisable = 1'b1;
    repeat (3) edgeChk();
    @(negedge btnClk) dirEnable = 4'b0000;
    edgeChk();
    check("disable_no_death", int'(busW.is_dead), 0);
    check("disable_v", int'(busW.vPos), 36);
    @(negedge btnClk) dirEnable = 4'b1111;
    edgeChk();
    @(negedge btnClk) playerDisable = 1'b0;
    repeat (10) edgeChk();
    check("disable_resume_v", int'(busW.vPos), 24);
    @(negedge btnClk) btns = 4'b0000;
    edgeChk();

    // death while pressing right, then respawn
    @(negedge btnClk) begin btns = 4'b0010; dirEnable = 4'b0000; end
    edgeChk();
    check("death_pulse", int'(busW.player_dead), 1);
    check("death_is_dead", int'(busW.is_dead), 1);
    check("death_h", int'(busW.hPos), 100);
    @(negedge btnClk) dirEnable = 4'b1111;
    edgeChk();
    check("death_pulse_once", int'(busW.player_dead), 0);
    check("death_still_dead", int'(busW.is_dead), 1);
    repeat (2) edgeChk();
    @(negedge btnClk) begin respawn = 1'b1; btns = 4'b0000; end
    edgeChk();
    check("respawn_v", int'(busW.vPos), 0);
    check("respawn_state", int'(busW.state), 0);
    @(negedge btnClk) respawn = 1'b0;
    edgeChk();

    // respawn outside DEAD is ignored
    @(negedge btnClk) respawn = 1'b1;
    edgeChk();
    @(negedge btnClk) respawn = 1'b0;

    // respawn with all directions blocked re-triggers death
    @(negedge btnClk) dirEnable = 4'b0000;
    edgeChk();
    @(negedge btnClk) respawn = 1'b1;
    edgeChk();
    check("redeath_respawned", int'(busW.state), 0);
    @(negedge btnClk) respawn = 1'b0;
    edgeChk();
    check("redeath_pulse", int'(busW.player_dead), 1);
    @(negedge btnClk) begin dirEnable = 4'b1111; respawn = 1'b1; end
    edgeChk();
    @(negedge btnClk) respawn = 1'b0;

    // diagonal press U+R
    @(negedge btnClk) begin rst = 1'b0; vStart = 12'd200; end
    edgeChk();
    @(negedge btnClk) begin rst = 1'b1; btns = 4'b1010; end
    edgeChk();
`ifdef PLAYER_DIAGONAL_EN
    check("diag_h", int'(busW.hPos), 112);
    check("diag_v", int'(busW.vPos), 188);
`else
    check("diag_h", int'(busW.hPos), 100);
    check("diag_v", int'(busW.vPos), 200);
    check("diag_state", int'(busW.state), 0);
`endif
    @(negedge btnClk) btns = 4'b0000;
    edgeChk();

    // reset in the middle of auto-repeat
    @(negedge btnClk) btns = 4'b0010;
    repeat (12) edgeChk();
    check("midrep_state", int'(busW.state), 2);
    @(negedge btnClk) rst = 1'b0;
    edgeChk();
    check("midrep_rst_h", int'(busW.hPos), 100);
    check("midrep_rst_state", int'(busW.state), 0);
    @(negedge btnClk) rst = 1'b1;
    edgeChk();
    check("midrep_restart_h", int'(busW.hPos), 112);
    for (int k = 2; k <= 9; k++) begin
      edgeChk();
      if (k == 8) check("midrep_k8_h", int'(busW.hPos), 112);
      if (k == 9) check("midrep_k9_h", int'(busW.hPos), 124);
    end
    @(negedge btnClk) btns = 4'b0000;
    repeat (2) edgeChk();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
